mem_wb_stage: RTL and testbench

// Dual-slot memory/writeback stage directly downstream of the execute stage.

---
 rtl/mem_wb_stage_if.sv | 21 ++
 rtl/mem_wb_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Shared data-memory port between the memory/writeback stage and the data memory.
interface mem_wb_stage_if #(
    parameter int XLEN = 32
) ();
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Dual-slot memory/writeback stage. Holds one execute bundle, serialises up to
// two memory accesses over a single port (slot 0 first), stalls execute while
// accesses are outstanding and drives two register-file write ports.
module mem_wb_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    output logic            stall_out,
    input  logic [XLEN-1:0] alu_res0,
    input  logic [XLEN-1:0] alu_res1,
    input  logic [XLEN-1:0] wdata0,
    input  logic [XLEN-1:0] wdata1,
    input  logic            mem_read0,
    input  logic            mem_read1,
    input  logic            mem_write0,
    input  logic            mem_write1,
    input  logic            reg_write0,
    input  logic            reg_write1,
    input  logic [REGW-1:0] rd0,
    input  logic [REGW-1:0] rd1,
    mem_wb_stage_if.master  dmem,
    output logic            wb_we0,
    output logic            wb_we1,
    output logic [REGW-1:0] wb_rd0,
    output logic [REGW-1:0] wb_rd1,
    output logic [XLEN-1:0] wb_data0,
    output logic [XLEN-1:0] wb_data1
);
    typedef enum logic [1:0] {RUN, MEM0, MEM1} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] res0_q, res0_d, res1_q, res1_d;
    logic [XLEN-1:0] wdata0_q, wdata0_d, wdata1_q, wdata1_d;
    logic            mem_read0_q, mem_read0_d, mem_read1_q, mem_read1_d;
    logic            mem_write0_q, mem_write0_d, mem_write1_q, mem_write1_d;
    logic            reg_write0_q, reg_write0_d, reg_write1_q, reg_write1_d;
    logic [REGW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic            wb_we0_q, wb_we0_d, wb_we1_q, wb_we1_d;
    logic [REGW-1:0] wb_rd0_q, wb_rd0_d, wb_rd1_q, wb_rd1_d;
    logic [XLEN-1:0] wb_data0_q, wb_data0_d, wb_data1_q, wb_data1_d;

    logic slot0_mem, slot1_mem, retire, we0_raw, we1_raw;

    // Retire decision: the held bundle leaves whenever its last access completes.
    always_comb begin
        slot0_mem = mem_read0_q | mem_write0_q;
        slot1_mem = mem_read1_q | mem_write1_q;
        retire    = (state_q == RUN)
                  | ((state_q == MEM0) & dmem.dmem_ready & ~slot1_mem)
                  | ((state_q == MEM1) & dmem.dmem_ready);
        stall_out = ~retire;
    end

    // Memory request driven straight from the held slot being serviced; loads win over stores.
    always_comb begin
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_wdata = '0;
        if (state_q == MEM0) begin
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = mem_write0_q & ~mem_read0_q;
            dmem.dmem_addr  = res0_q;
            dmem.dmem_wdata = wdata0_q;
        end else if (state_q == MEM1) begin
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = mem_write1_q & ~mem_read1_q;
            dmem.dmem_addr  = res1_q;
            dmem.dmem_wdata = wdata1_q;
        end
    end

    // Next state: capture load data, retire to the write ports, then consume the new bundle.
    always_comb begin
        state_d      = state_q;
        res0_d       = res0_q;
        res1_d       = res1_q;
        wdata0_d     = wdata0_q;
        wdata1_d     = wdata1_q;
        mem_read0_d  = mem_read0_q;
        mem_read1_d  = mem_read1_q;
        mem_write0_d = mem_write0_q;
        mem_write1_d = mem_write1_q;
        reg_write0_d = reg_write0_q;
        reg_write1_d = reg_write1_q;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        wb_we0_d     = 1'b0;
        wb_we1_d     = 1'b0;
        wb_rd0_d     = wb_rd0_q;
        wb_rd1_d     = wb_rd1_q;
        wb_data0_d   = wb_data0_q;
        wb_data1_d   = wb_data1_q;
        we0_raw      = reg_write0_q & (rd0_q != '0);
        we1_raw      = reg_write1_q & (rd1_q != '0);

        // Load data overwrites the held result so the retire path sees one source.
        if ((state_q == MEM0) && dmem.dmem_ready && mem_read0_q) res0_d = dmem.dmem_rdata;
        if ((state_q == MEM1) && dmem.dmem_ready && mem_read1_q) res1_d = dmem.dmem_rdata;

        if ((state_q == MEM0) && dmem.dmem_ready && slot1_mem) state_d = MEM1;

        if (retire) begin
            wb_we0_d   = we0_raw & ~(we1_raw & (rd0_q == rd1_q));
            wb_we1_d   = we1_raw;
            wb_rd0_d   = rd0_q;
            wb_rd1_d   = rd1_q;
            wb_data0_d = res0_d;
            wb_data1_d = res1_d;

            res0_d       = alu_res0;
            res1_d       = alu_res1;
            wdata0_d     = wdata0;
            wdata1_d     = wdata1;
            mem_read0_d  = mem_read0;
            mem_read1_d  = mem_read1;
            mem_write0_d = mem_write0;
            mem_write1_d = mem_write1;
            reg_write0_d = reg_write0;
            reg_write1_d = reg_write1;
            rd0_d        = rd0;
            rd1_d        = rd1;
            if (mem_read0 | mem_write0)      state_d = MEM0;
            else if (mem_read1 | mem_write1) state_d = MEM1;
            else                             state_d = RUN;
        end
    end

    // State, held bundle and write-port registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            res0_q       <= '0;
            res1_q       <= '0;
            wdata0_q     <= '0;
            wdata1_q     <= '0;
            mem_read0_q  <= 1'b0;
            mem_read1_q  <= 1'b0;
            mem_write0_q <= 1'b0;
            mem_write1_q <= 1'b0;
            reg_write0_q <= 1'b0;
            reg_write1_q <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
            wb_we0_q     <= 1'b0;
            wb_we1_q     <= 1'b0;
            wb_rd0_q     <= '0;
            wb_rd1_q     <= '0;
            wb_data0_q   <= '0;
            wb_data1_q   <= '0;
        end else begin
            state_q      <= state_d;
            res0_q       <= res0_d;
            res1_q       <= res1_d;
            wdata0_q     <= wdata0_d;
            wdata1_q     <= wdata1_d;
            mem_read0_q  <= mem_read0_d;
            mem_read1_q  <= mem_read1_d;
            mem_write0_q <= mem_write0_d;
            mem_write1_q <= mem_write1_d;
            reg_write0_q <= reg_write0_d;
            reg_write1_q <= reg_write1_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            wb_we0_q     <= wb_we0_d;
            wb_we1_q     <= wb_we1_d;
            wb_rd0_q     <= wb_rd0_d;
            wb_rd1_q     <= wb_rd1_d;
            wb_data0_q   <= wb_data0_d;
            wb_data1_q   <= wb_data1_d;
        end
    end

    assign wb_we0   = wb_we0_q;
    assign wb_we1   = wb_we1_q;
    assign wb_rd0   = wb_rd0_q;
    assign wb_rd1   = wb_rd1_q;
    assign wb_data0 = wb_data0_q;
    assign wb_data1 = wb_data1_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed bundles plus random traffic, compared
// against a transaction-level model of accesses, timing and write-back.
module tb_mem_wb_stage;
    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef struct packed {
        logic [XLEN-1:0] res0, res1, wd0, wd1;
        logic            mr0, mw0, rw0, mr1, mw1, rw1;
        logic [REGW-1:0] rd0, rd1;
    } bundle_t;

    logic clk = 1'b0;
    logic reset;
    logic stall_out;
    logic [XLEN-1:0] alu_res0, alu_res1, wdata0, wdata1;
    logic mem_read0, mem_read1, mem_write0, mem_write1, reg_write0, reg_write1;
    logic [REGW-1:0] rd0, rd1;
    logic wb_we0, wb_we1;
    logic [REGW-1:0] wb_rd0, wb_rd1;
    logic [XLEN-1:0] wb_data0, wb_data1;

    int n_checks = 0;
    int n_pass   = 0;

    mem_wb_stage_if #(.XLEN(XLEN)) dmem_if ();

    mem_wb_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .reset(reset), .stall_out(stall_out),
        .alu_res0(alu_res0), .alu_res1(alu_res1),
        .wdata0(wdata0), .wdata1(wdata1),
        .mem_read0(mem_read0), .mem_read1(mem_read1),
        .mem_write0(mem_write0), .mem_write1(mem_write1),
        .reg_write0(reg_write0), .reg_write1(reg_write1),
        .rd0(rd0), .rd1(rd1),
        .dmem(dmem_if),
        .wb_we0(wb_we0), .wb_we1(wb_we1),
        .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
        .wb_data0(wb_data0), .wb_data1(wb_data1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Memory contents seen by loads: a fixed function of the address.
    function automatic logic [XLEN-1:0] mem_val(input logic [XLEN-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic drive(input bundle_t b);
        alu_res0 = b.res0;  alu_res1 = b.res1;
        wdata0 = b.wd0;     wdata1 = b.wd1;
        mem_read0 = b.mr0;  mem_write0 = b.mw0; reg_write0 = b.rw0;
        mem_read1 = b.mr1;  mem_write1 = b.mw1; reg_write1 = b.rw1;
        rd0 = b.rd0;        rd1 = b.rd1;
    endtask

    // Entered just after the edge that consumed h; returns just after the edge it retires on.
    task automatic step(input bundle_t h, input int w0, input int w1, input bundle_t nxt, input logic [XLEN-1:0] rdata_override);
        logic [XLEN-1:0] a_addr [2];
        logic [XLEN-1:0] a_wd [2];
        logic            a_we [2];
        int              a_w [2];
        int              n;
        logic [XLEN-1:0] d0, d1;
        logic            e0, e1;
        drive(nxt);
        n = 0;
        if (h.mr0 | h.mw0) begin a_addr[n] = h.res0; a_wd[n] = h.wd0; a_we[n] = ~h.mr0; a_w[n] = w0; n++; end
        if (h.mr1 | h.mw1) begin a_addr[n] = h.res1; a_wd[n] = h.wd1; a_we[n] = ~h.mr1; a_w[n] = w1; n++; end
        if (n == 0) begin
            @(negedge clk);
            chk("run_req", 32'(dmem_if.dmem_req), 0);
            chk("run_addr", dmem_if.dmem_addr, 0);
            chk("run_stall", 32'(stall_out), 0);
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i < n; i++) begin
                for (int c = 0; c <= a_w[i]; c++) begin
                    dmem_if.dmem_ready = (c == a_w[i]);
                    dmem_if.dmem_rdata = (rdata_override != 0) ? rdata_override : mem_val(a_addr[i]);
                    @(negedge clk);
                    chk("req", 32'(dmem_if.dmem_req), 1);
                    chk("addr", dmem_if.dmem_addr, a_addr[i]);
                    chk("we", 32'(dmem_if.dmem_we), 32'(a_we[i]));
                    chk("wdata", dmem_if.dmem_wdata, a_wd[i]);
                    chk("stall", 32'(stall_out), (i == n - 1 && c == a_w[i]) ? 0 : 1);
                    @(posedge clk); #1;
                    if (!(i == n - 1 && c == a_w[i])) begin
                        chk("idle_we0", 32'(wb_we0), 0);
                        chk("idle_we1", 32'(wb_we1), 0);
                    end
                end
            end
            dmem_if.dmem_ready = 1'b0;
        end
        d0 = h.mr0 ? ((rdata_override != 0) ? rdata_override : mem_val(h.res0)) : h.res0;
        d1 = h.mr1 ? ((rdata_override != 0) ? rdata_override : mem_val(h.res1)) : h.res1;
        e1 = h.rw1 && h.rd1 != 0;
        e0 = h.rw0 && h.rd0 != 0 && !(e1 && h.rd0 == h.rd1);
        chk("wb_we0", 32'(wb_we0), 32'(e0));
        chk("wb_we1", 32'(wb_we1), 32'(e1));
        chk("wb_rd0", 32'(wb_rd0), 32'(h.rd0));
        chk("wb_rd1", 32'(wb_rd1), 32'(h.rd1));
        chk("wb_data0", wb_data0, d0);
        chk("wb_data1", wb_data1, d1);
    endtask

    bundle_t q_b [$];
    int      q_w0 [$];
    int      q_w1 [$];

    task automatic push(input bundle_t b, input int w0, input int w1);
        q_b.push_back(b); q_w0.push_back(w0); q_w1.push_back(w1);
    endtask

    // Consume q_b[0] then run every queued bundle through to retirement.
    task automatic run_queue();
        bundle_t bub;
        bub = '0;
        drive(q_b[0]);
        @(posedge clk); #1;
        for (int i = 0; i < q_b.size(); i++)
            step(q_b[i], q_w0[i], q_w1[i], (i + 1 < q_b.size()) ? q_b[i + 1] : bub,
                 (i == 1) ? 32'hDEAD_BEEF : 32'h0);
        q_b.delete(); q_w0.delete(); q_w1.delete();
    endtask

    initial begin
        bundle_t b, bub;
        bub = '0;
        reset = 1'b1;
        drive(bub);
        dmem_if.dmem_ready = 1'b0;
        dmem_if.dmem_rdata = '0;
        #12;
        chk("rst_stall", 32'(stall_out), 0);
        chk("rst_req", 32'(dmem_if.dmem_req), 0);
        chk("rst_we0", 32'(wb_we0), 0);
        chk("rst_we1", 32'(wb_we1), 0);
        chk("rst_data1", wb_data1, 0);
        @(negedge clk);
        reset = 1'b0;

        // ALU pair
        b = '0; b.res0 = 32'h11; b.rd0 = 3; b.rw0 = 1; b.res1 = 32'h22; b.rd1 = 4; b.rw1 = 1;
        push(b, 0, 0);
        // slot 0 load with three wait cycles, load data forced to DEADBEEF
        b = '0; b.res0 = 32'h100; b.mr0 = 1; b.rw0 = 1; b.rd0 = 5; b.res1 = 32'h33; b.rw1 = 1; b.rd1 = 6;
        push(b, 3, 0);
        // store on slot 0, load on slot 1
        b = '0; b.res0 = 32'h40; b.wd0 = 32'h5A; b.mw0 = 1; b.res1 = 32'h44; b.mr1 = 1; b.rw1 = 1; b.rd1 = 9;
        push(b, 0, 0);
        // same destination on both slots, then x0 destinations
        b = '0; b.res0 = 32'hAAAA; b.res1 = 32'hBBBB; b.rw0 = 1; b.rw1 = 1; b.rd0 = 7; b.rd1 = 7;
        push(b, 0, 0);
        b = '0; b.res0 = 32'h1; b.res1 = 32'h2; b.rw0 = 1; b.rw1 = 1;
        push(b, 0, 0);
        // read and write both set: read wins; slot1-only store with waits
        b = '0; b.res0 = 32'h80; b.wd0 = 32'h77; b.mr0 = 1; b.mw0 = 1; b.rw0 = 1; b.rd0 = 10;
        b.res1 = 32'h90; b.wd1 = 32'h99; b.mw1 = 1;
        push(b, 1, 2);
        // back-to-back loads with immediate ready
        for (int i = 0; i < 4; i++) begin
            b = '0; b.res0 = 32'h200 + 32'(i * 4); b.mr0 = 1; b.rw0 = 1; b.rd0 = REGW'(i + 11);
            push(b, 0, 0);
        end
        run_queue();

        // random traffic
        for (int i = 0; i < 200; i++) begin
            b.res0 = $urandom; b.res1 = $urandom; b.wd0 = $urandom; b.wd1 = $urandom;
            b.mr0 = ($urandom_range(0, 3) == 0); b.mw0 = ($urandom_range(0, 3) == 0);
            b.mr1 = ($urandom_range(0, 3) == 0); b.mw1 = ($urandom_range(0, 3) == 0);
            b.rw0 = 1'($urandom_range(0, 1)); b.rw1 = 1'($urandom_range(0, 1));
            b.rd0 = REGW'($urandom_range(0, 7)); b.rd1 = REGW'($urandom_range(0, 7));
            push(b, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_queue();

        // reset in the middle of a pending slot 0 access
        b = '0; b.res0 = 32'h300; b.mr0 = 1; b.rw0 = 1; b.rd0 = 12;
        drive(b);
        dmem_if.dmem_ready = 1'b0;
        @(posedge clk); #1;
        drive(bub);
        @(negedge clk);
        chk("pre_rst_req", 32'(dmem_if.dmem_req), 1);
        chk("pre_rst_stall", 32'(stall_out), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_req", 32'(dmem_if.dmem_req), 0);
        chk("async_stall", 32'(stall_out), 0);
        chk("async_addr", dmem_if.dmem_addr, 0);
        chk("async_we0", 32'(wb_we0), 0);
        chk("async_rd0", 32'(wb_rd0), 0);
        chk("async_data0", wb_data0, 0);
        @(posedge clk); #1;
        chk("hold_rst_req", 32'(dmem_if.dmem_req), 0);
        @(negedge clk);
        reset = 1'b0;

        b = '0; b.res0 = 32'h55; b.rw0 = 1; b.rd0 = 2; b.res1 = 32'h404; b.mr1 = 1; b.rw1 = 1; b.rd1 = 8;
        push(b, 0, 1);
        b = '0; b.res0 = 32'h66; b.rw0 = 1; b.rd0 = 1;
        push(b, 0, 0);
        run_queue();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
